// File: rtl/collision_engine_if.sv
// Bus bundle between the game control FSM, the level-map memory and collision_engine.
// The engine takes the slave side; the control/memory side takes the master side.
interface collision_engine_if #(
    parameter int N_ENT = 2
) ();
    logic                 start;
    logic [9*N_ENT-1:0]   x_in;
    logic [8*N_ENT-1:0]   y_in;
    logic [2*N_ENT-1:0]   dir_in;
    logic [N_ENT-1:0]     move_in;
    logic [N_ENT-1:0]     active_in;
    logic [16:0]          map_addr;
    logic                 map_q;
    logic                 busy;
    logic                 done;
    logic [N_ENT-1:0]     map_col;
    logic [N_ENT-1:0]     hit_col;

    modport master (
        output start, x_in, y_in, dir_in, move_in, active_in, map_q,
        input  map_addr, busy, done, map_col, hit_col
    );

    modport slave (
        input  start, x_in, y_in, dir_in, move_in, active_in, map_q,
        output map_addr, busy, done, map_col, hit_col
    );
endinterface

// File: rtl/collision_engine.sv
// Time-multiplexed collision engine: probes two leading corners per entity against the
// level map, then tests player-vs-enemy probe-box overlap, and reports with a done pulse.
module collision_engine #(
    parameter int N_ENT    = 2,
    parameter int STEP     = 16,
    parameter int SIZE     = 16,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic              clock,
    input  logic              reset,
    collision_engine_if.slave bus
);
    localparam int EW = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam logic [EW-1:0]      LAST   = EW'(N_ENT - 1);
    localparam logic signed [9:0]  STEP_S = 10'(STEP);
    localparam logic signed [11:0] SIZE_S = 12'(SIZE);
    localparam logic signed [11:0] W_LIM  = 12'(SCREEN_W - SIZE);
    localparam logic signed [11:0] H_LIM  = 12'(SCREEN_H - SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_MAP_REQ, S_MAP_SAMPLE, S_PAIR, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11
    } dir_t;

    state_t             state_q, state_d;
    logic [EW-1:0]      ent_q, ent_d;
    logic               probe_q, probe_d;
    logic signed [9:0]  px_q [N_ENT];
    logic signed [9:0]  px_d [N_ENT];
    logic signed [9:0]  py_q [N_ENT];
    logic signed [9:0]  py_d [N_ENT];
    dir_t               dir_q [N_ENT];
    dir_t               dir_d [N_ENT];
    logic [N_ENT-1:0]   move_q, move_d;
    logic [N_ENT-1:0]   act_q, act_d;
    logic [N_ENT-1:0]   map_scr_q, map_scr_d;
    logic [N_ENT-1:0]   hit_scr_q, hit_scr_d;
    logic [N_ENT-1:0]   map_col_q, map_col_d;
    logic [N_ENT-1:0]   hit_col_q, hit_col_d;

    logic signed [11:0] box_x, box_y, corner_x, corner_y;
    logic signed [11:0] dx, dy;
    dir_t               cur_dir;
    logic               oob;
    logic               overlap;

    // Corner of the probe box currently addressed by ent_q/probe_q, and its bounds test.
    always_comb begin
        box_x    = 12'(px_q[ent_q]);
        box_y    = 12'(py_q[ent_q]);
        cur_dir  = dir_q[ent_q];
        corner_x = box_x;
        corner_y = box_y;
        if (cur_dir == DIR_RIGHT || (probe_q && (cur_dir == DIR_UP || cur_dir == DIR_DOWN)))
            corner_x = box_x + (SIZE_S - 12'sd1);
        if (cur_dir == DIR_DOWN || (probe_q && (cur_dir == DIR_LEFT || cur_dir == DIR_RIGHT)))
            corner_y = box_y + (SIZE_S - 12'sd1);
        oob = box_x[11] || box_y[11] || (box_x > W_LIM) || (box_y > H_LIM);

        dx      = 12'(px_q[0]) - box_x;
        dy      = 12'(py_q[0]) - box_y;
        overlap = act_q[0] && act_q[ent_q]
               && (dx > -SIZE_S) && (dx < SIZE_S)
               && (dy > -SIZE_S) && (dy < SIZE_S);
    end

    always_comb begin
        state_d   = state_q;
        ent_d     = ent_q;
        probe_d   = probe_q;
        px_d      = px_q;
        py_d      = py_q;
        dir_d     = dir_q;
        move_d    = move_q;
        act_d     = act_q;
        map_scr_d = map_scr_q;
        hit_scr_d = hit_scr_q;
        map_col_d = map_col_q;
        hit_col_d = hit_col_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LATCH;
            end
            S_LATCH: begin
                for (int unsigned i = 0; i < N_ENT; i++) begin
                    px_d[i]  = {1'b0, bus.x_in[9*i +: 9]};
                    py_d[i]  = {2'b00, bus.y_in[8*i +: 8]};
                    dir_d[i] = dir_t'(bus.dir_in[2*i +: 2]);
                    if (bus.move_in[i]) begin
                        unique case (dir_d[i])
                            DIR_UP:    py_d[i] = py_d[i] - STEP_S;
                            DIR_DOWN:  py_d[i] = py_d[i] + STEP_S;
                            DIR_LEFT:  px_d[i] = px_d[i] - STEP_S;
                            DIR_RIGHT: px_d[i] = px_d[i] + STEP_S;
                        endcase
                    end
                end
                move_d    = bus.move_in;
                act_d     = bus.active_in;
                map_scr_d = '0;
                hit_scr_d = '0;
                ent_d     = '0;
                probe_d   = 1'b0;
                state_d   = S_MAP_REQ;
            end
            S_MAP_REQ: begin
                state_d = S_MAP_SAMPLE;
            end
            S_MAP_SAMPLE: begin
                if (act_q[ent_q] && move_q[ent_q] && (oob || !bus.map_q))
                    map_scr_d[ent_q] = 1'b1;
                if (!probe_q) begin
                    probe_d = 1'b1;
                    state_d = S_MAP_REQ;
                end else if (ent_q != LAST) begin
                    probe_d = 1'b0;
                    ent_d   = ent_q + 1'b1;
                    state_d = S_MAP_REQ;
                end else begin
                    probe_d = 1'b0;
                    if (N_ENT > 1) begin
                        ent_d   = EW'(1);
                        state_d = S_PAIR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_PAIR: begin
                if (overlap) hit_scr_d[ent_q] = 1'b1;
                if (ent_q == LAST) state_d = S_DONE;
                else               ent_d   = ent_q + 1'b1;
            end
            S_DONE: begin
                ent_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Results publish on entry to DONE so they are valid while done is high.
        if (state_d == S_DONE) begin
            map_col_d = map_scr_d;
            hit_col_d = hit_scr_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ent_q     <= '0;
            probe_q   <= 1'b0;
            for (int unsigned i = 0; i < N_ENT; i++) begin
                px_q[i]  <= '0;
                py_q[i]  <= '0;
                dir_q[i] <= DIR_UP;
            end
            move_q    <= '0;
            act_q     <= '0;
            map_scr_q <= '0;
            hit_scr_q <= '0;
            map_col_q <= '0;
            hit_col_q <= '0;
        end else begin
            state_q   <= state_d;
            ent_q     <= ent_d;
            probe_q   <= probe_d;
            px_q      <= px_d;
            py_q      <= py_d;
            dir_q     <= dir_d;
            move_q    <= move_d;
            act_q     <= act_d;
            map_scr_q <= map_scr_d;
            hit_scr_q <= hit_scr_d;
            map_col_q <= map_col_d;
            hit_col_q <= hit_col_d;
        end
    end

    always_comb begin
        bus.map_addr = '0;
        if (state_q == S_MAP_REQ && !oob)
            bus.map_addr = 17'(corner_y) * 17'(SCREEN_W) + 17'(corner_x);
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.map_col = map_col_q;
    assign bus.hit_col = hit_col_q;
endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine: vector table on a 2-entity engine plus
// hand sequences for restart, reset abort, held start, and 4-/1-entity builds.
module tb_collision_engine;
    localparam logic [16:0] NONE = 17'h1FFFF;
    localparam int U = 0, D = 1, L = 2, R = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    collision_engine_if #(.N_ENT(2)) b2 ();
    collision_engine_if #(.N_ENT(4)) b4 ();
    collision_engine_if #(.N_ENT(1)) b1 ();

    collision_engine #(.N_ENT(2)) dut2 (.clock(clock), .reset(reset), .bus(b2));
    collision_engine #(.N_ENT(4)) dut4 (.clock(clock), .reset(reset), .bus(b4));
    collision_engine #(.N_ENT(1)) dut1 (.clock(clock), .reset(reset), .bus(b1));

    // Level map: every pixel walkable except one blocked address per engine.
    logic [16:0] blk2 = NONE, blk4 = NONE, blk1 = NONE;
    always @(posedge clock) begin
        b2.map_q <= (b2.map_addr != blk2);
        b4.map_q <= (b4.map_addr != blk4);
        b1.map_q <= (b1.map_addr != blk1);
    end

    typedef struct {
        logic [8:0]  x0, x1;
        logic [7:0]  y0, y1;
        logic [1:0]  d0, d1;
        logic [1:0]  mv, act;
        logic [16:0] blk;
        logic [1:0]  emap, ehit;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int x0, y0, d0, x1, y1, d1, mv, act, blk, emap, ehit);
        vec_t v;
        v.x0 = 9'(x0);  v.y0 = 8'(y0);  v.d0 = 2'(d0);
        v.x1 = 9'(x1);  v.y1 = 8'(y1);  v.d1 = 2'(d1);
        v.mv = 2'(mv);  v.act = 2'(act); v.blk = 17'(blk);
        v.emap = 2'(emap); v.ehit = 2'(ehit);
        return v;
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            2:       return b2.done;
            4:       return b4.done;
            default: return b1.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            2:       return b2.busy;
            4:       return b4.busy;
            default: return b1.busy;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            2:       b2.start = v;
            4:       b4.start = v;
            default: b1.start = v;
        endcase
    endtask

    // Pulse start so it is sampled at edge 0; return the cycle index of done.
    task automatic run_pass(input int sel, input int budget, output int lat, output int busy_ok);
        lat = -1;
        busy_ok = 1;
        @(negedge clock);
        set_start(sel, 1'b1);
        @(posedge clock);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock);
            if (c == 1) set_start(sel, 1'b0);
            if (!get_busy(sel)) busy_ok = 0;
            if (get_done(sel)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic apply2(input vec_t v, input int idx);
        int lat, bok;
        b2.x_in      = {v.x1, v.x0};
        b2.y_in      = {v.y1, v.y0};
        b2.dir_in    = {v.d1, v.d0};
        b2.move_in   = v.mv;
        b2.active_in = v.act;
        blk2         = v.blk;
        run_pass(2, 40, lat, bok);
        check($sformatf("vec%0d latency", idx), lat, 11);
        check($sformatf("vec%0d busy", idx), bok, 1);
        check($sformatf("vec%0d map_col", idx), int'(b2.map_col), int'(v.emap));
        check($sformatf("vec%0d hit_col", idx), int'(b2.hit_col), int'(v.ehit));
        @(negedge clock);
        check($sformatf("vec%0d after_done busy/done", idx), int'({b2.busy, b2.done}), 0);
    endtask

    vec_t vt[15];

    initial begin
        int lat, bok, ndone, first, second, nbusy;

        vt[0]  = mk(100, 100, R, 200,  50, U, 1, 3, NONE,  0, 0);
        vt[1]  = mk(100, 100, R, 200,  50, U, 1, 3, 32131, 1, 0);
        vt[2]  = mk(100, 100, R, 200,  50, U, 0, 3, 32131, 0, 0);
        vt[3]  = mk(  0,  50, L, 200,  50, U, 1, 3, NONE,  1, 0);
        vt[4]  = mk(304,  50, R, 200,  50, U, 1, 3, NONE,  1, 0);
        vt[5]  = mk(100, 100, R, 132, 100, U, 1, 3, NONE,  0, 0);
        vt[6]  = mk(100, 100, R, 131, 100, U, 1, 3, NONE,  0, 2);
        vt[7]  = mk(100, 100, R, 131, 100, U, 1, 1, NONE,  0, 0);
        vt[8]  = mk(100, 100, R, 200,  50, U, 2, 3, 11080, 2, 0);
        vt[9]  = mk(  0,  50, L, 200,  50, U, 1, 2, NONE,  0, 0);
        vt[10] = mk(100, 224, D, 200,  50, U, 1, 3, NONE,  1, 0);
        vt[11] = mk(100, 208, D, 200,  50, U, 1, 3, NONE,  0, 0);
        vt[12] = mk(100, 100, U, 100,  70, D, 3, 3, NONE,  0, 2);
        vt[13] = mk(100, 100, D, 200,  50, U, 1, 3, 42035, 1, 0);
        vt[14] = mk(100, 100, L, 200,  50, U, 1, 3, 36884, 1, 0);

        b2.start = 1'b0; b2.x_in = '0; b2.y_in = '0; b2.dir_in = '0; b2.move_in = '0; b2.active_in = '0;
        b4.start = 1'b0; b4.x_in = '0; b4.y_in = '0; b4.dir_in = '0; b4.move_in = '0; b4.active_in = '0;
        b1.start = 1'b0; b1.x_in = '0; b1.y_in = '0; b1.dir_in = '0; b1.move_in = '0; b1.active_in = '0;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset busy/done", int'({b2.busy, b2.done, b4.busy, b4.done}), 0);
        check("reset map_col", int'(b2.map_col), 0);
        check("reset hit_col", int'(b2.hit_col), 0);
        check("reset map_addr", int'(b2.map_addr), 0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) apply2(vt[i], i);

        // Restart pulse during MAP_SAMPLE is ignored; outputs hold the previous pass meanwhile.
        b2.x_in = {9'd200, 9'd100}; b2.y_in = {8'd50, 8'd100}; b2.dir_in = {2'd0, 2'd3};
        b2.move_in = 2'b01; b2.active_in = 2'b11; blk2 = NONE;
        ndone = 0; first = -1;
        @(negedge clock); b2.start = 1'b1; @(posedge clock);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (c == 1) b2.start = 1'b0;
            if (c == 2) check("map_addr probe0", int'(b2.map_addr), 32131);
            if (c == 3) b2.start = 1'b1;
            if (c == 4) begin
                b2.start = 1'b0;
                check("map_addr probe1", int'(b2.map_addr), 36931);
            end
            if (c == 5) begin
                check("hold map_col", int'(b2.map_col), 1);
                check("hold hit_col", int'(b2.hit_col), 0);
            end
            if (b2.done) begin
                ndone++;
                if (first < 0) first = c;
            end
        end
        check("restart done count", ndone, 1);
        check("restart done cycle", first, 11);
        check("restart map_col", int'(b2.map_col), 0);

        // start held through DONE: second pass from the following IDLE cycle.
        b2.x_in = {9'd200, 9'd0}; b2.y_in = {8'd50, 8'd50}; b2.dir_in = {2'd0, 2'd2};
        ndone = 0; first = -1; second = -1;
        @(negedge clock); b2.start = 1'b1; @(posedge clock);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (c == 2) check("map_addr oob", int'(b2.map_addr), 0);
            if (c == 13) b2.start = 1'b0;
            if (b2.done) begin
                ndone++;
                if (first < 0) first = c;
                else second = c;
            end
        end
        check("held start done count", ndone, 2);
        check("held start first done", first, 11);
        check("held start second done", second, 23);
        check("held start map_col", int'(b2.map_col), 1);

        // Reset in PAIR aborts the pass and clears published results.
        apply2(mk(100, 100, R, 131, 100, U, 1, 3, 32131, 1, 2), 99);
        @(negedge clock); b2.start = 1'b1; @(posedge clock);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 1) b2.start = 1'b0;
        end
        check("pair busy", int'(b2.busy), 1);
        reset = 1'b0;
        #1;
        check("abort busy/done", int'({b2.busy, b2.done}), 0);
        check("abort map_col", int'(b2.map_col), 0);
        check("abort hit_col", int'(b2.hit_col), 0);
        check("abort map_addr", int'(b2.map_addr), 0);
        @(negedge clock); reset = 1'b1;
        ndone = 0; nbusy = 0;
        repeat (20) begin
            @(negedge clock);
            if (b2.done) ndone++;
            if (b2.busy) nbusy++;
        end
        check("abort no done", ndone, 0);
        check("abort idle", nbusy, 0);
        check("abort outputs stay 0", int'({b2.map_col, b2.hit_col}), 0);

        // Four entities: enemies 1 and 3 overlap the player, enemy 2 walks into a wall.
        b4.x_in = {9'd100, 9'd200, 9'd110, 9'd100};
        b4.y_in = {8'd90, 8'd50, 8'd100, 8'd100};
        b4.dir_in = '0; b4.move_in = 4'b0100; b4.active_in = 4'b1111; blk4 = 17'd11080;
        run_pass(4, 60, lat, bok);
        check("n4 latency", lat, 21);
        check("n4 busy", bok, 1);
        check("n4 map_col", int'(b4.map_col), 4'b0100);
        check("n4 hit_col", int'(b4.hit_col), 4'b1010);
        b4.active_in = 4'b0011;
        run_pass(4, 60, lat, bok);
        check("n4 inactive latency", lat, 21);
        check("n4 inactive map_col", int'(b4.map_col), 0);
        check("n4 inactive hit_col", int'(b4.hit_col), 4'b0010);

        // Single entity: PAIR skipped.
        b1.x_in = 9'd0; b1.y_in = 8'd50; b1.dir_in = 2'd2; b1.move_in = 1'b1; b1.active_in = 1'b1;
        run_pass(1, 30, lat, bok);
        check("n1 latency", lat, 6);
        check("n1 busy", bok, 1);
        check("n1 map_col oob", int'(b1.map_col), 1);
        check("n1 hit_col", int'(b1.hit_col), 0);
        b1.x_in = 9'd100; b1.dir_in = 2'd3;
        run_pass(1, 30, lat, bok);
        check("n1 clear latency", lat, 6);
        check("n1 map_col clear", int'(b1.map_col), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
